// File: rtl/tilt_direction_filter.sv
// Tick-sampled moving average, deadband classifier and per-axis debounce driving one-hot
// tilt flags. Define TILT_FILTER_CALIBRATE_EN to make the rest centres recalibratable.
module tilt_direction_filter #(
  parameter int unsigned SAMPLE_DIV   = 100000,
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned X_CENTER     = 385,
  parameter int unsigned Y_CENTER     = 80,
  parameter int unsigned DEADBAND     = 8,
  parameter int unsigned STABLE_COUNT = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [8:0] accel_x_i,
  input  logic [8:0] accel_y_i,
  input  logic       calibrate_i,
  output logic       up_o,
  output logic       down_o,
  output logic       rest_x_o,
  output logic       left_o,
  output logic       right_o,
  output logic       rest_y_o,
  output logic       dir_valid_o
);

  localparam int unsigned DW    = 9;
  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SW    = DW + AVG_LOG2;
  localparam int unsigned PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned HW    = 1 << PW;
  localparam int unsigned TW    = $clog2(SAMPLE_DIV);
  localparam int unsigned FW    = AVG_LOG2 + 1;
  localparam int unsigned CW    = $clog2(STABLE_COUNT + 1);
  localparam int unsigned OW    = 6;

  typedef enum logic [1:0] {CLS_REST = 2'd0, CLS_POS = 2'd1, CLS_NEG = 2'd2} cls_e;
  typedef enum logic {ST_COMMITTED = 1'b0, ST_PENDING = 1'b1} deb_state_e;

  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [PW-1:0]      wptr_q, wptr_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [DW-1:0]      hist_q [2][HW];
  logic [DW-1:0]      hist_d [2][HW];
  logic [SW-1:0]      sum_q [2];
  logic [SW-1:0]      sum_d [2];
  cls_e               com_q [2];
  cls_e               com_d [2];
  cls_e               pend_q [2];
  cls_e               pend_d [2];
  deb_state_e         st_q [2];
  deb_state_e         st_d [2];
  logic [CW-1:0]      cnt_q [2];
  logic [CW-1:0]      cnt_d [2];
  logic [CW-1:0]      cnt_n_c [2];
  logic [OW-1:0]      out_q, out_d;
  logic               dv_q, dv_d;

  logic               tick_c, warm_c, cal_c;
  logic [DW-1:0]      samp_c [2];
  logic [DW-1:0]      avg_c [2];
  logic [DW-1:0]      cen_c [2];
  logic signed [10:0] delta_c [2];
  cls_e               cand_c [2];

  assign samp_c[0] = accel_x_i;
  assign samp_c[1] = accel_y_i;

`ifdef TILT_FILTER_CALIBRATE_EN
  logic [DW-1:0] cen_q [2];
  logic [DW-1:0] cen_d [2];
  assign cen_c[0] = cen_q[0];
  assign cen_c[1] = cen_q[1];
`else
  logic unused_calibrate;
  assign unused_calibrate = calibrate_i;
  assign cen_c[0] = DW'(X_CENTER);
  assign cen_c[1] = DW'(Y_CENTER);
`endif

  // Sampling, averaging, classification and debounce for both axes
  always_comb begin
    tick_c = (tcnt_q == TW'(SAMPLE_DIV - 1));
    tcnt_d = tick_c ? '0 : tcnt_q + TW'(1);
    warm_c = (fill_q == FW'(DEPTH));
    wptr_d = wptr_q;
    fill_d = fill_q;
`ifdef TILT_FILTER_CALIBRATE_EN
    cal_c  = calibrate_i && warm_c;
`else
    cal_c  = 1'b0;
`endif
    if (tick_c) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (!warm_c) fill_d = fill_q + FW'(1);
    end
    for (int a = 0; a < 2; a++) begin
      hist_d[a]  = hist_q[a];
      sum_d[a]   = sum_q[a];
      com_d[a]   = com_q[a];
      pend_d[a]  = pend_q[a];
      st_d[a]    = st_q[a];
      cnt_d[a]   = cnt_q[a];
      cnt_n_c[a] = '0;
`ifdef TILT_FILTER_CALIBRATE_EN
      cen_d[a]   = cal_c ? DW'(sum_q[a] >> AVG_LOG2) : cen_q[a];
`endif
      if (tick_c) begin
        sum_d[a]          = sum_q[a] + SW'(samp_c[a]) - SW'(hist_q[a][wptr_q]);
        hist_d[a][wptr_q] = samp_c[a];
      end
      avg_c[a]   = DW'(sum_d[a] >> AVG_LOG2);
      delta_c[a] = $signed({2'b00, avg_c[a]}) - $signed({2'b00, cen_c[a]});
      if (delta_c[a] > $signed(11'(DEADBAND)))       cand_c[a] = CLS_POS;
      else if (delta_c[a] < -$signed(11'(DEADBAND))) cand_c[a] = CLS_NEG;
      else                                           cand_c[a] = CLS_REST;

      if (cal_c) begin
        com_d[a]  = CLS_REST;
        pend_d[a] = CLS_REST;
        st_d[a]   = ST_COMMITTED;
        cnt_d[a]  = '0;
      end else if (tick_c && warm_c) begin
        if (cand_c[a] == com_q[a]) begin
          st_d[a]  = ST_COMMITTED;
          cnt_d[a] = '0;
        end else begin
          if (cand_c[a] == pend_q[a]) begin
            cnt_n_c[a] = cnt_q[a] + CW'(1);
          end else begin
            pend_d[a]  = cand_c[a];
            cnt_n_c[a] = CW'(1);
          end
          st_d[a]  = ST_PENDING;
          cnt_d[a] = cnt_n_c[a];
          if (cnt_n_c[a] >= CW'(STABLE_COUNT)) begin
            com_d[a] = cand_c[a];
            st_d[a]  = ST_COMMITTED;
            cnt_d[a] = '0;
          end
        end
      end
    end
    out_d = {com_q[0] == CLS_POS, com_q[0] == CLS_NEG, com_q[0] == CLS_REST,
             com_q[1] == CLS_NEG, com_q[1] == CLS_POS, com_q[1] == CLS_REST};
    dv_d  = (out_d != out_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      out_q  <= 6'b001001;
      dv_q   <= 1'b0;
      for (int a = 0; a < 2; a++) begin
        for (int k = 0; k < int'(HW); k++) hist_q[a][k] <= '0;
        sum_q[a]  <= '0;
        com_q[a]  <= CLS_REST;
        pend_q[a] <= CLS_REST;
        st_q[a]   <= ST_COMMITTED;
        cnt_q[a]  <= '0;
      end
`ifdef TILT_FILTER_CALIBRATE_EN
      cen_q[0] <= DW'(X_CENTER);
      cen_q[1] <= DW'(Y_CENTER);
`endif
    end else begin
      tcnt_q <= tcnt_d;
      wptr_q <= wptr_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      dv_q   <= dv_d;
      for (int a = 0; a < 2; a++) begin
        hist_q[a] <= hist_d[a];
        sum_q[a]  <= sum_d[a];
        com_q[a]  <= com_d[a];
        pend_q[a] <= pend_d[a];
        st_q[a]   <= st_d[a];
        cnt_q[a]  <= cnt_d[a];
`ifdef TILT_FILTER_CALIBRATE_EN
        cen_q[a]  <= cen_d[a];
`endif
      end
    end
  end

  assign {up_o, down_o, rest_x_o, left_o, right_o, rest_y_o} = out_q;
  assign dir_valid_o = dv_q;

endmodule

// File: tb/tb_tilt_direction_filter.sv
// Randomised bench for tilt_direction_filter: two instances (window 4 and window 1)
// checked every cycle against a sample-history model, plus directed literal checks.
module tb_tilt_direction_filter;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int SC = 3;
  localparam logic [6:0] REST_O = 7'b0010010;

  logic       clk, rst_n, cal;
  logic [8:0] ax, ay;
  logic       up0, dn0, rx0, lf0, rt0, ry0, dv0;
  logic       up1, dn1, rx1, lf1, rt1, ry1, dv1;
  logic [6:0] got [2];

  int nvec = 0;
  int nerr = 0;

  tilt_direction_filter #(.SAMPLE_DIV(SD), .AVG_LOG2(2), .X_CENTER(385), .Y_CENTER(80),
                          .DEADBAND(DB), .STABLE_COUNT(SC)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .accel_x_i(ax), .accel_y_i(ay), .calibrate_i(cal),
    .up_o(up0), .down_o(dn0), .rest_x_o(rx0), .left_o(lf0), .right_o(rt0), .rest_y_o(ry0),
    .dir_valid_o(dv0));

  tilt_direction_filter #(.SAMPLE_DIV(SD), .AVG_LOG2(0), .X_CENTER(385), .Y_CENTER(80),
                          .DEADBAND(DB), .STABLE_COUNT(SC)) u_dut_w1 (
    .clk_i(clk), .rst_ni(rst_n), .accel_x_i(ax), .accel_y_i(ay), .calibrate_i(cal),
    .up_o(up1), .down_o(dn1), .rest_x_o(rx1), .left_o(lf1), .right_o(rt1), .rest_y_o(ry1),
    .dir_valid_o(dv1));

  assign got[0] = {up0, dn0, rx0, lf0, rt0, ry0, dv0};
  assign got[1] = {up1, dn1, rx1, lf1, rt1, ry1, dv1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: last-N sample history, run-length debounce (0=rest 1=pos 2=neg)
  int dep [2] = '{4, 1};
  int hx [2][16];
  int hy [2][16];
  int fillm [2], cenx [2], ceny [2], avgx [2], avgy [2];
  int comx [2], comy [2], rcx [2], rcy [2], rlx [2], rly [2];
  logic [6:0] exp_o [2];
  int tcnt;
  event tick_ev;

  function automatic int classify(input int avg, input int cen);
    int d;
    d = avg - cen;
    if (d > DB) return 1;
    if (d < -DB) return 2;
    return 0;
  endfunction

  task automatic deb(input int cand, input int com_i, input int rc_i, input int rl_i,
                     output int com_o, output int rc_o, output int rl_o);
    com_o = com_i; rc_o = rc_i; rl_o = rl_i;
    if (cand == com_i) begin
      rl_o = 0;
    end else begin
      rl_o = (cand == rc_i) ? rl_i + 1 : 1;
      rc_o = cand;
      if (rl_o >= SC) begin
        com_o = cand;
        rl_o  = 0;
      end
    end
  endtask

  function automatic logic [5:0] dirs(input int cx, input int cy);
    return {cx == 1, cx == 2, cx == 0, cy == 2, cy == 1, cy == 0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt = 0;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 16; k++) begin hx[i][k] = 0; hy[i][k] = 0; end
        fillm[i] = 0; cenx[i] = 385; ceny[i] = 80; avgx[i] = 0; avgy[i] = 0;
        comx[i] = 0; comy[i] = 0; rcx[i] = 0; rcy[i] = 0; rlx[i] = 0; rly[i] = 0;
        exp_o[i] = REST_O;
      end
    end else begin
      bit tick;
      tick = (tcnt == SD - 1);
      tcnt = tick ? 0 : tcnt + 1;
      for (int i = 0; i < 2; i++) begin
        logic [5:0] nd;
        bit calhit;
        int sx, sy;
        nd = dirs(comx[i], comy[i]);
        exp_o[i] = {nd, nd != exp_o[i][6:1]};
        calhit = 0;
`ifdef TILT_FILTER_CALIBRATE_EN
        if (cal && fillm[i] == dep[i]) begin
          cenx[i] = avgx[i]; ceny[i] = avgy[i];
          comx[i] = 0; comy[i] = 0; rlx[i] = 0; rly[i] = 0;
          calhit = 1;
        end
`endif
        if (tick) begin
          for (int k = dep[i] - 1; k > 0; k--) begin
            hx[i][k] = hx[i][k-1]; hy[i][k] = hy[i][k-1];
          end
          hx[i][0] = int'(ax); hy[i][0] = int'(ay);
          sx = 0; sy = 0;
          for (int k = 0; k < dep[i]; k++) begin sx += hx[i][k]; sy += hy[i][k]; end
          avgx[i] = sx / dep[i];
          avgy[i] = sy / dep[i];
          if (fillm[i] == dep[i]) begin
            if (!calhit) begin
              deb(classify(avgx[i], cenx[i]), comx[i], rcx[i], rlx[i], comx[i], rcx[i], rlx[i]);
              deb(classify(avgy[i], ceny[i]), comy[i], rcy[i], rly[i], comy[i], rcy[i], rly[i]);
            end
          end else begin
            fillm[i]++;
          end
        end
      end
      if (tick) -> tick_ev;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      nvec++;
      if (got[i] !== exp_o[i]) begin
        nerr++;
        $display("FAIL dut%0d cycle_outputs got=%b exp=%b t=%0t", i, got[i], exp_o[i], $time);
      end
    end
  end

  int dv0_cnt = 0, dv1_cnt = 0, left1_cnt = 0;
  always @(negedge clk) begin
    if (dv0 === 1'b1) dv0_cnt++;
    if (dv1 === 1'b1) dv1_cnt++;
    if (lf1 === 1'b1) left1_cnt++;
  end

  task automatic check(input string nm, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(tick_ev);
  endtask

  task automatic settle_out();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int b0, b1, bl;
    rst_n = 1'b0; cal = 1'b0; ax = 9'd385; ay = 9'd80;
    repeat (3) @(negedge clk);
    check("reset_out0", int'(got[0]), int'(REST_O));
    check("reset_out1", int'(got[1]), int'(REST_O));
    rst_n = 1'b1;

    // Centred input never moves the outputs
    b0 = dv0_cnt;
    ticks(20); @(negedge clk);
    check("hold_center_dv", dv0_cnt - b0, 0);
    check("hold_center_out", int'(got[0]), int'(REST_O));

    // Step 385 -> 400 commits up after the fifth tick
    b0 = dv0_cnt;
    ax = 9'd400;
    ticks(1);
    check("step_avg1", avgx[0], 388);
    ticks(3);
    check("step_avg4", avgx[0], 400);
    settle_out();
    check("step_up_tick4", int'(up0), 0);
    ticks(1);
    settle_out();
    check("step_up_tick5", int'({up0, rx0}), 2);
    ticks(3); @(negedge clk);
    check("step_dv_pulses", dv0_cnt - b0, 1);

    // Deadband edge: delta 8 rests, delta 9 tilts
    ax = 9'd393; ticks(10); @(negedge clk);
    check("deadband_8_rest", int'(rx0), 1);
    ax = 9'd394; ticks(10); @(negedge clk);
    check("deadband_9_up", int'(up0), 1);

    // Window-1 instance: two-tick glitch rejected, three-tick excursion commits
    ax = 9'd385; ay = 9'd80; ticks(8); @(negedge clk);
    b1 = dv1_cnt; bl = left1_cnt;
    ay = 9'd40;
    ticks(2);
    check("w1_avg_y", avgy[1], 40);
    @(negedge clk); ay = 9'd80;
    ticks(6); @(negedge clk);
    check("w1_glitch_left", left1_cnt - bl, 0);
    check("w1_glitch_dv", dv1_cnt - b1, 0);
    ay = 9'd40;
    ticks(3); settle_out();
    check("w1_left_commit", int'(lf1), 1);
    ay = 9'd80; ticks(6); @(negedge clk);

    // Asynchronous reset mid-run with up asserted
    ax = 9'd420; ticks(10); @(negedge clk);
    check("pre_reset_up", int'(up0), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("async_reset_out0", int'(got[0]), int'(REST_O));
    check("async_reset_out1", int'(got[1]), int'(REST_O));
    @(negedge clk); rst_n = 1'b1;
    ax = 9'd385;
    ticks(8); @(negedge clk);

`ifdef TILT_FILTER_CALIBRATE_EN
    ax = 9'd300; ticks(12); @(negedge clk);
    check("cal_pre_down", int'(dn0), 1);
    b0 = dv0_cnt;
    cal = 1'b1; @(negedge clk); cal = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("cal_rest_x", int'(rx0), 1);
    check("cal_dv_pulse", dv0_cnt - b0, 1);
    ax = 9'd310; ticks(8); settle_out();
    check("cal_up_after", int'(up0), 1);
    ax = 9'd385; ticks(8); @(negedge clk);
`endif

    // Randomised segments around both centres, with occasional calibrate pulses
    for (int s = 0; s < 400; s++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) ax = 9'($urandom);
      else                           ax = 9'(385 + int'($urandom_range(0, 48)) - 24);
      if ($urandom_range(0, 7) == 0) ay = 9'($urandom);
      else                           ay = 9'(80 + int'($urandom_range(0, 48)) - 24);
      if ($urandom_range(0, 15) == 0) begin
        cal = 1'b1; @(negedge clk); cal = 1'b0;
      end
      ticks(int'($urandom_range(1, 6)));
    end
    settle_out();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tilt_direction_filter.md
Name: tilt_direction_filter

Overview:
- Sits between the accelerometer controller and the tilt-direction consumers (game movement logic, status LEDs).
- Samples the raw 9-bit X/Y accelerometer readings at a fixed rate and smooths them with a moving average.
- Applies a deadband around a centre value, then debounces each axis.
- Drives registered one-hot direction flags per axis: up/down/rest_x and left/right/rest_y. These replace single-sample compares against fixed centre values.

Parameters:
- SAMPLE_DIV, 100000: clocks per sample tick (1 kHz at 100 MHz); minimum 2.
- AVG_LOG2, 2: moving-average window is 2^AVG_LOG2 samples; range 0..4.
- X_CENTER, 385: X rest value.
- Y_CENTER, 80: Y rest value.
- DEADBAND, 8: half-width of the rest zone, in counts.
- STABLE_COUNT, 3: consecutive ticks a new class must persist before it is committed; minimum 1.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- accel_x  in  9  raw X reading, sampled only on a tick
- accel_y  in  9  raw Y reading, sampled only on a tick
- calibrate  in  1  recentre request; used only with CALIBRATE_EN
- up  out  1  X tilted positive
- down  out  1  X tilted negative
- rest_x  out  1  X inside the deadband
- left  out  1  Y tilted negative
- right  out  1  Y tilted positive
- rest_y  out  1  Y inside the deadband
- dir_valid  out  1  one-cycle pulse when any direction output changes

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Reset assertion clears all state immediately, including mid-operation.
- Reset values: rest_x=1, rest_y=1; up, down, left, right and dir_valid = 0. History, sums, counters and debounce state = 0.
- Tick counter: counts 0..SAMPLE_DIV-1, then wraps to 0. The tick is asserted for the one cycle in which the count equals SAMPLE_DIV-1.
- Averaging, per axis:
  - 2^AVG_LOG2-entry ring buffer plus a running sum of width 9+AVG_LOG2.
  - On each tick: sum <= sum + new - oldest, and new overwrites oldest.
  - avg = sum >> AVG_LOG2 (floor).
- Warm-up: a fill counter counts the first 2^AVG_LOG2 ticks after reset. No classification happens until it saturates, so outputs hold their reset values.
- Classification, per axis, on each tick after warm-up:
  - delta = avg - CENTER, 11-bit signed, with avg zero-extended.
  - delta > DEADBAND gives POS (X->up, Y->right).
  - delta < -DEADBAND gives NEG (X->down, Y->left).
  - Otherwise REST; |delta| == DEADBAND is REST.
- Debounce FSM, per axis. States are COMMITTED and PENDING; registers are committed class, pending class and a count.
  - Candidate == committed: go to COMMITTED and clear count.
  - Candidate != committed and == pending: count += 1.
  - Candidate != committed and != pending: pending <= candidate, count = 1.
  - When count reaches STABLE_COUNT: committed <= pending, return to COMMITTED.
- Output timing: outputs are registered from the committed class, one-hot per axis. They update one clock after the committing tick.
- dir_valid: asserted in that same output-update cycle when either axis changed. Both axes changing on the same tick produce a single pulse.
- Latency: a step input commits after (averaging settle + STABLE_COUNT) ticks, plus 1 clock.
- Between ticks, accel_x and accel_y are ignored.

Optional Feature:
- Macro: TILT_FILTER_CALIBRATE_EN.
- With the macro defined:
  - Centres are registers, reset to X_CENTER/Y_CENTER.
  - calibrate high while warm-up is complete loads both centres from the current avg on the next clock.
  - That load forces both committed classes to REST and clears the debounce state.
  - dir_valid pulses if any output changed.
  - calibrate during warm-up is ignored. A calibrate coinciding with a tick takes priority over classification for that tick.
- Without the macro: centres are the fixed parameters and the calibrate port is ignored.

Test Plan:
All scenarios use SAMPLE_DIV=4, AVG_LOG2=2, DEADBAND=8, STABLE_COUNT=3 unless stated otherwise.
- Reset low mid-run with up=1 -> same cycle: rest_x=1, rest_y=1, up/down/left/right=0, dir_valid=0.
- Hold x=385, y=80 for 20 ticks -> outputs stay rest and dir_valid never pulses.
- After warm-up, step x 385->400 -> avg sequence 388, 392, 396, 400. up=1 and rest_x=0 one clock after the 5th tick, with a single dir_valid pulse.
- Steady x=393 -> rest_x stays 1 (delta=8). Steady x=394 -> up commits (delta=9).
- AVG_LOG2=0: y=40 for 2 ticks then back to 80 -> left never asserts and no dir_valid. y=40 for 3 ticks -> left=1 after the 3rd tick.
- With TILT_FILTER_CALIBRATE_EN: hold x=300 until down=1, pulse calibrate -> rest_x=1 plus a dir_valid pulse. Then x=310 -> up=1 after settle plus 3 ticks.
